hp48_bus_ram: RTL and testbench
===============================

Name: hp48_bus_ram

Overview:
- Parametrised nibble-wide RAM device for the HP48 Saturn bus.
- Tracks the bus PC and DP pointers and serves PC/DP reads and writes inside a configurable address window.
- Supports the configure/unconfigure/reset bus protocol and a daisy-chain configuration priority, so several instances (I/O RAM, main RAM, port RAM) share one bus.
- Sits alongside the other bus devices; its nibble_out and active outputs feed the bus controller read mux.

Parameters:
- RAM_LEN, 64: depth in nibbles; power of two, 16..65536.
- ADDR_W, 20: bus address width.
- CMD_W, 4: bus command width.

Ports:
- clk  in  1  bus clock; all state changes on the falling edge.
- reset  in  1  asynchronous, active-high reset.
- address  in  ADDR_W  bus address for LOAD_PC, LOAD_DP, CONFIGURE, UNCONFIGURE.
- command  in  CMD_W  bus command, from the shared bus command encodings.
- nibble_in  in  4  write data.
- daisy_in  in  1  configuration enable from the upstream device (tie high on the first device).
- nibble_out  out  4  registered read data.
- active  out  1  combinational; this device owns the current read/write cycle.
- daisy_out  out  1  high when fully configured; feeds the next device's daisy_in.
- error  out  1  sticky protocol error.

Behaviour:
- Reset (async) clears state:
  - state=UNCONF; base=0; len_mask=RAM_LEN-1; pc_ptr=0; dp_ptr=0.
  - nibble_out=0; error=0; daisy_out=0.
  - Memory contents are not cleared.
- States: UNCONF, SIZED, CONFIGURED.
  - UNCONF -> SIZED on CONFIGURE when daisy_in=1; latches the size.
  - SIZED -> CONFIGURED on CONFIGURE when daisy_in=1; latches base=address & ~len_mask.
  - CONFIGURED -> UNCONF on UNCONFIGURE when address is inside the window.
  - Any state -> UNCONF on the RESET bus command.
  - CONFIGURE with daisy_in=0, or while CONFIGURED, is ignored.
- Size encoding: size = (2^ADDR_W - address) mod 2^ADDR_W.
  - Legal: a power of two with size <= RAM_LEN; sets len_mask = size-1.
  - Illegal: sets error and leaves the state unchanged.
- Window hit for pointer p: ((p - base) mod 2^ADDR_W) & ~len_mask == 0.
- active = CONFIGURED & error=0 & hit, tested on:
  - pc_ptr for PC_READ and PC_WRITE;
  - dp_ptr for DP_READ and DP_WRITE;
  - 0 for all other commands.
- Pointer tracking, done for every command regardless of hit or state, so all devices stay coherent:
  - LOAD_PC / LOAD_DP load address.
  - PC_READ / PC_WRITE increment pc_ptr.
  - DP_READ / DP_WRITE increment dp_ptr.
  - Increments wrap mod 2^ADDR_W.
- Memory index = (ptr - base) & len_mask.
- Reads with active=1: nibble_out is loaded on the same falling edge and valid until the next read; it holds its value otherwise.
- Writes with active=1: mem[idx] <= nibble_in. Writes with active=0 are dropped without error.
- Back-to-back reads/writes sustain one nibble per cycle with no bubbles.
- A pointer increment and the access it addresses in the same cycle use the pre-increment value.
- NOP: no effect.
- Unknown command: sets error. While error=1:
  - access and configure are suppressed;
  - pointers still track;
  - the RESET command or the reset pin clears it.
- Reset asserted mid-access aborts the write; memory is left unchanged.

Optional Feature:
- Macro: HP48_BUS_RAM_FIXED_SIZE_EN.
- Defined: the SIZED state is removed. A single CONFIGURE from UNCONF with daisy_in=1 goes straight to CONFIGURED, with len_mask=RAM_LEN-1 and base=address & ~len_mask. Size legality errors cannot occur.
- Undefined: two-step size-then-address configure, as above.

Decomposition:
- Shared package: bus command encodings (NOP, PC_READ, PC_WRITE, DP_READ, DP_WRITE, LOAD_PC, LOAD_DP, CONFIGURE, UNCONFIGURE, RESET), ADDR_W default, nibble width constant, config state encoding.
- One sub-module: hp48_bus_window, the combinational base/len_mask hit and index calculator, reused by the ROM and port devices.

Test Plan:
- Size then address configure: reset; CONFIGURE 0xFFFC0 (size 64), CONFIGURE 0x00100 -> daisy_out=1. LOAD_DP 0x00100; DP_WRITE A,B,C -> dp_ptr=0x00103. LOAD_PC 0x00100; 3x PC_READ -> nibble_out A,B,C, one per cycle, active=1.
- Window edges: configure at 0x00100, size 64. LOAD_PC 0x000FF + PC_READ -> active=0, pc_ptr still increments. Reads at 0x0013F -> active=1; at 0x00140 -> active=0.
- Daisy priority: daisy_in=0, two CONFIGUREs -> state stays UNCONF, daisy_out=0. Raise daisy_in, repeat -> configured.
- Illegal size: CONFIGURE 0xFFF00 (size 256 > RAM_LEN=64) -> error=1; later DP_WRITE ignored; RESET bus command -> error=0, state UNCONF.
- Unconfigure and wrap: configure at 0xFFFC0; LOAD_DP 0xFFFFF, DP_WRITE 5 -> dp_ptr wraps to 0x00000. UNCONFIGURE 0xFFFC0 -> daisy_out=0, later reads active=0.
- Async reset mid-write: assert reset between edges during DP_WRITE burst -> all outputs 0 immediately; the aborted nibble is not written.

Source files
------------

// File: rtl/hp48_bus_ram_pkg.sv
// rtl/hp48_bus_ram_pkg.sv - shared Saturn bus command encodings and RAM device config states
package hp48_bus_ram_pkg;

  localparam int ADDR_W_DEF = 20;
  localparam int CMD_W_DEF  = 4;
  localparam int NIB_W      = 4;

  typedef enum logic [3:0] {
    CMD_NOP         = 4'd0,
    CMD_PC_READ     = 4'd1,
    CMD_PC_WRITE    = 4'd2,
    CMD_DP_READ     = 4'd3,
    CMD_DP_WRITE    = 4'd4,
    CMD_LOAD_PC     = 4'd5,
    CMD_LOAD_DP     = 4'd6,
    CMD_CONFIGURE   = 4'd7,
    CMD_UNCONFIGURE = 4'd8,
    CMD_RESET       = 4'd9
  } bus_cmd_e;

  typedef enum logic [1:0] {
    CFG_UNCONF     = 2'd0,
    CFG_SIZED      = 2'd1,
    CFG_CONFIGURED = 2'd2
  } cfg_state_e;

endpackage

// File: rtl/hp48_bus_ram_if.sv
// rtl/hp48_bus_ram_if.sv - Saturn bus signals seen by one RAM device, with master/slave views
interface hp48_bus_ram_if
  import hp48_bus_ram_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int CMD_W  = CMD_W_DEF
);
  logic [ADDR_W-1:0] address;
  logic [CMD_W-1:0]  command;
  logic [NIB_W-1:0]  nibble_in;
  logic              daisy_in;
  logic [NIB_W-1:0]  nibble_out;
  logic              active;
  logic              daisy_out;
  logic              error;

  modport master (
    output address, command, nibble_in, daisy_in,
    input  nibble_out, active, daisy_out, error
  );

  modport slave (
    input  address, command, nibble_in, daisy_in,
    output nibble_out, active, daisy_out, error
  );
endinterface

// File: rtl/hp48_bus_window.sv
// rtl/hp48_bus_window.sv - combinational base/len_mask window hit and memory index calculator
module hp48_bus_window #(
  parameter int ADDR_W = 20,
  parameter int IDX_W  = 6
) (
  input  logic [ADDR_W-1:0] i_ptr,
  input  logic [ADDR_W-1:0] i_base,
  input  logic [ADDR_W-1:0] i_len_mask,
  output logic              o_hit,
  output logic [IDX_W-1:0]  o_idx
);
  logic [ADDR_W-1:0] w_off;

  // Offset wraps mod 2^ADDR_W so windows straddling the top of memory still hit.
  assign w_off = i_ptr - i_base;
  assign o_hit = (w_off & ~i_len_mask) == '0;
  assign o_idx = w_off[IDX_W-1:0] & i_len_mask[IDX_W-1:0];
endmodule

// File: rtl/hp48_bus_ram.sv
// rtl/hp48_bus_ram.sv - nibble RAM on the Saturn bus; HP48_BUS_RAM_FIXED_SIZE_EN gives one-step configure
module hp48_bus_ram
  import hp48_bus_ram_pkg::*;
#(
  parameter int RAM_LEN = 64,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int CMD_W   = CMD_W_DEF
) (
  input  logic           clk,
  input  logic           reset,
  hp48_bus_ram_if.slave  bus
);
  localparam int                IDX_W     = $clog2(RAM_LEN);
  localparam logic [ADDR_W-1:0] FULL_MASK = ADDR_W'(RAM_LEN - 1);

  cfg_state_e        r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_base, r_len_mask, r_pc_ptr, r_dp_ptr;
  logic              r_error;
  logic [NIB_W-1:0]  r_nibble_out;
  logic [NIB_W-1:0]  r_mem [RAM_LEN];

  logic              w_is_pc, w_is_dp, w_is_rd, w_is_wr, w_unknown;
  logic [ADDR_W-1:0] w_win_ptr;
  logic              w_hit, w_active, w_daisy;
  logic [IDX_W-1:0]  w_idx;
  logic              w_cfg_err, w_set_size, w_set_base;

  assign w_is_pc   = (bus.command == CMD_W'(CMD_PC_READ)) || (bus.command == CMD_W'(CMD_PC_WRITE));
  assign w_is_dp   = (bus.command == CMD_W'(CMD_DP_READ)) || (bus.command == CMD_W'(CMD_DP_WRITE));
  assign w_is_rd   = (bus.command == CMD_W'(CMD_PC_READ)) || (bus.command == CMD_W'(CMD_DP_READ));
  assign w_is_wr   = (bus.command == CMD_W'(CMD_PC_WRITE)) || (bus.command == CMD_W'(CMD_DP_WRITE));
  assign w_unknown = bus.command > CMD_W'(CMD_RESET);

  // One window serves the access pointer, or the bus address for UNCONFIGURE.
  assign w_win_ptr = w_is_pc ? r_pc_ptr : (w_is_dp ? r_dp_ptr : bus.address);

  hp48_bus_window #(.ADDR_W(ADDR_W), .IDX_W(IDX_W)) u_window (
    .i_ptr      (w_win_ptr),
    .i_base     (r_base),
    .i_len_mask (r_len_mask),
    .o_hit      (w_hit),
    .o_idx      (w_idx)
  );

`ifndef HP48_BUS_RAM_FIXED_SIZE_EN
  logic [ADDR_W-1:0] w_size;
  logic              w_size_ok;
  assign w_size    = '0 - bus.address;
  assign w_size_ok = (w_size != '0) && ((w_size & (w_size - ADDR_W'(1))) == '0)
                     && (w_size <= ADDR_W'(RAM_LEN));
`endif

  always_ff @(negedge clk or posedge reset) begin
    if (reset) r_state <= CFG_UNCONF;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cfg_err   = 1'b0;
    w_set_size  = 1'b0;
    w_set_base  = 1'b0;
    if (bus.command == CMD_W'(CMD_RESET)) begin
      w_state_nxt = CFG_UNCONF;
    end else if (!r_error) begin
      if ((bus.command == CMD_W'(CMD_CONFIGURE)) && bus.daisy_in) begin
        case (r_state)
`ifdef HP48_BUS_RAM_FIXED_SIZE_EN
          CFG_UNCONF: begin
            w_state_nxt = CFG_CONFIGURED;
            w_set_base  = 1'b1;
          end
`else
          CFG_UNCONF: begin
            if (w_size_ok) begin
              w_state_nxt = CFG_SIZED;
              w_set_size  = 1'b1;
            end else begin
              w_cfg_err = 1'b1;
            end
          end
          CFG_SIZED: begin
            w_state_nxt = CFG_CONFIGURED;
            w_set_base  = 1'b1;
          end
`endif
          default: ;
        endcase
      end else if ((bus.command == CMD_W'(CMD_UNCONFIGURE)) && (r_state == CFG_CONFIGURED) && w_hit) begin
        w_state_nxt = CFG_UNCONF;
      end
    end
  end

  always_comb begin
    w_active = (w_is_pc || w_is_dp) && (r_state == CFG_CONFIGURED) && !r_error && w_hit;
    w_daisy  = r_state == CFG_CONFIGURED;
  end

  always_ff @(negedge clk or posedge reset) begin
    if (reset) begin
      r_base       <= '0;
      r_len_mask   <= FULL_MASK;
      r_pc_ptr     <= '0;
      r_dp_ptr     <= '0;
      r_error      <= 1'b0;
      r_nibble_out <= '0;
    end else begin
`ifndef HP48_BUS_RAM_FIXED_SIZE_EN
      if (w_set_size) r_len_mask <= w_size - ADDR_W'(1);
`endif
      if (w_set_base) r_base <= bus.address & ~r_len_mask;
      if (bus.command == CMD_W'(CMD_RESET))  r_error <= 1'b0;
      else if (w_unknown || w_cfg_err)       r_error <= 1'b1;
      // Pointers track every command so all devices on the bus stay coherent.
      if (bus.command == CMD_W'(CMD_LOAD_PC)) r_pc_ptr <= bus.address;
      else if (w_is_pc)                       r_pc_ptr <= r_pc_ptr + ADDR_W'(1);
      if (bus.command == CMD_W'(CMD_LOAD_DP)) r_dp_ptr <= bus.address;
      else if (w_is_dp)                       r_dp_ptr <= r_dp_ptr + ADDR_W'(1);
      if (w_active && w_is_rd) r_nibble_out <= r_mem[w_idx];
    end
  end

  always_ff @(negedge clk) begin
    if (!reset && w_active && w_is_wr) r_mem[w_idx] <= bus.nibble_in;
  end

  assign bus.nibble_out = r_nibble_out;
  assign bus.active     = w_active;
  assign bus.daisy_out  = w_daisy;
  assign bus.error      = r_error;
endmodule

// File: tb/tb_hp48_bus_ram.sv
// tb/tb_hp48_bus_ram.sv - scoreboard bench for hp48_bus_ram against a behavioural bus RAM model
module tb_hp48_bus_ram;
  import hp48_bus_ram_pkg::*;

  localparam int RAM_LEN = 64;
  localparam int ADDR_W  = 20;
  localparam int CMD_W   = 4;
  localparam int unsigned AMOD = 32'h100000;

  logic clk = 1'b0;
  logic reset = 1'b1;

  hp48_bus_ram_if #(.ADDR_W(ADDR_W), .CMD_W(CMD_W)) bus ();

  hp48_bus_ram #(.RAM_LEN(RAM_LEN), .ADDR_W(ADDR_W), .CMD_W(CMD_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit    active;
    bit    chk_nib;
    int    nib;
    bit    daisy;
    bit    err;
    string name;
  } exp_t;

  exp_t q[$];
  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: state 0=unconfigured, 1=sized, 2=configured; window is [base, base+len).
  int          m_state, m_len, m_nib;
  int unsigned m_base, m_pc, m_dp;
  bit          m_err, m_nib_known;
  int          m_mem[RAM_LEN];
  bit          m_known[RAM_LEN];

  function automatic void check(string name, int act, int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endfunction

  function automatic void model_reset();
    m_state = 0; m_len = RAM_LEN; m_base = 0; m_pc = 0; m_dp = 0;
    m_err = 0; m_nib = 0; m_nib_known = 1;
  endfunction

  function automatic bit m_hit(int unsigned p);
    return ((p - m_base) % AMOD) < m_len;
  endfunction

  function automatic int m_idx(int unsigned p);
    return int'(((p - m_base) % AMOD) % m_len);
  endfunction

  task automatic issue(input int cmd, input int unsigned addr, input int nib, input bit daisy,
                       input string name);
    exp_t        e;
    int unsigned p;
    int unsigned size;
    bit          acc;
    @(posedge clk); #1;
    bus.command   = cmd[3:0];
    bus.address   = addr[19:0];
    bus.nibble_in = nib[3:0];
    bus.daisy_in  = daisy;
    acc = (cmd >= 1 && cmd <= 4);
    p   = (cmd == 1 || cmd == 2) ? m_pc : m_dp;
    e.active = acc && m_state == 2 && !m_err && m_hit(p);
    case (cmd)
      1, 3: if (e.active) begin m_nib = m_mem[m_idx(p)]; m_nib_known = m_known[m_idx(p)]; end
      2, 4: if (e.active) begin m_mem[m_idx(p)] = nib & 15; m_known[m_idx(p)] = 1; end
      default: ;
    endcase
    if (cmd == 1 || cmd == 2) m_pc = (m_pc + 1) % AMOD;
    if (cmd == 3 || cmd == 4) m_dp = (m_dp + 1) % AMOD;
    if (cmd == 5) m_pc = addr % AMOD;
    if (cmd == 6) m_dp = addr % AMOD;
    if (cmd == 7 && daisy && !m_err) begin
      if (m_state == 0) begin
        size = (AMOD - addr % AMOD) % AMOD;
        if (size != 0 && size <= RAM_LEN && (size & (size - 1)) == 0) begin
          m_len = int'(size); m_state = 1;
        end else m_err = 1;
      end else if (m_state == 1) begin
        m_base = addr % AMOD - (addr % AMOD) % m_len; m_state = 2;
      end
    end
    if (cmd == 8 && !m_err && m_state == 2 && m_hit(addr % AMOD)) m_state = 0;
    if (cmd == 9) begin m_state = 0; m_err = 0; end
    if (cmd >= 10) m_err = 1;
    e.chk_nib = m_nib_known;
    e.nib     = m_nib;
    e.daisy   = m_state == 2;
    e.err     = m_err;
    e.name    = name;
    q.push_back(e);
  endtask

  task automatic drain();
    int n = 0;
    @(posedge clk); #1;
    bus.command = 4'(CMD_NOP);
    while (q.size() != 0 && n < 20) begin @(posedge clk); n++; end
    check("drain_timeout", q.size(), 0);
    q.delete();
    @(negedge clk); #2;
  endtask

  // Monitor: active is sampled just before the falling edge, registered outputs just after.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk); #4;
      if (q.size() != 0) begin
        e = q.pop_front();
        check({e.name, ".active"}, int'(bus.active), int'(e.active));
        @(negedge clk); #1;
        if (e.chk_nib) check({e.name, ".nibble_out"}, int'(bus.nibble_out), e.nib);
        check({e.name, ".daisy_out"}, int'(bus.daisy_out), int'(e.daisy));
        check({e.name, ".error"}, int'(bus.error), int'(e.err));
      end
    end
  end

  initial begin
    #400000;
    n_fail++;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    int r, cmd;
    int unsigned a;
    bus.command = '0; bus.address = '0; bus.nibble_in = '0; bus.daisy_in = 1'b1;
    model_reset();
    for (int i = 0; i < RAM_LEN; i++) begin m_mem[i] = 0; m_known[i] = 0; end
    #3;
    check("reset.nibble_out", int'(bus.nibble_out), 0);
    check("reset.active", int'(bus.active), 0);
    check("reset.daisy_out", int'(bus.daisy_out), 0);
    check("reset.error", int'(bus.error), 0);
    @(negedge clk); #2;
    reset = 1'b0;

    issue(7, 32'hFFFC0, 0, 1, "cfg_size");
    issue(7, 32'h00100, 0, 1, "cfg_base");
    issue(6, 32'h00100, 0, 1, "load_dp");
    issue(4, 0, 4'hA, 1, "dpw_a");
    issue(4, 0, 4'hB, 1, "dpw_b");
    issue(4, 0, 4'hC, 1, "dpw_c");
    for (int i = 3; i < RAM_LEN; i++) issue(4, 0, int'($urandom_range(0, 15)), 1, "dpw_fill");
    issue(5, 32'h00100, 0, 1, "load_pc");
    issue(1, 0, 0, 1, "pcr_a");
    issue(1, 0, 0, 1, "pcr_b");
    issue(1, 0, 0, 1, "pcr_c");
    issue(1, 0, 0, 1, "pcr_d");

    issue(5, 32'h000FF, 0, 1, "load_pc_below");
    issue(1, 0, 0, 1, "pcr_below");
    issue(1, 0, 0, 1, "pcr_after_below");
    issue(5, 32'h0013F, 0, 1, "load_pc_top");
    issue(1, 0, 0, 1, "pcr_top");
    issue(1, 0, 0, 1, "pcr_above");

    issue(9, 0, 0, 1, "bus_reset1");
    issue(7, 32'hFFFC0, 0, 0, "cfg_nodaisy1");
    issue(7, 32'h00100, 0, 0, "cfg_nodaisy2");
    issue(7, 32'hFFFC0, 0, 1, "cfg_daisy1");
    issue(7, 32'h00100, 0, 1, "cfg_daisy2");

    issue(9, 0, 0, 1, "bus_reset2");
    issue(7, 32'hFFF00, 0, 1, "cfg_illegal");
    issue(6, 32'h00100, 0, 1, "load_dp_err");
    issue(4, 0, 5, 1, "dpw_err");
    issue(9, 0, 0, 1, "bus_reset3");
    issue(7, 32'hFFFC0, 0, 1, "cfg_size2");
    issue(7, 32'h00100, 0, 1, "cfg_base2");
    issue(5, 32'h00100, 0, 1, "load_pc2");
    issue(1, 0, 0, 1, "pcr_after_err");

    issue(9, 0, 0, 1, "bus_reset4");
    issue(7, 32'hFFFC0, 0, 1, "cfg_size3");
    issue(7, 32'hFFFC0, 0, 1, "cfg_base3");
    issue(6, 32'hFFFFF, 0, 1, "load_dp_top");
    issue(4, 0, 5, 1, "dpw_top");
    issue(3, 0, 0, 1, "dpr_wrapped");
    issue(8, 32'hFFFC0, 0, 1, "unconfigure");
    issue(5, 32'hFFFFF, 0, 1, "load_pc_unc");
    issue(1, 0, 0, 1, "pcr_unc");

    issue(7, 32'hFFFC0, 0, 1, "cfg_size4");
    issue(7, 32'h00100, 0, 1, "cfg_base4");
    issue(12, 0, 0, 1, "unknown_cmd");
    issue(5, 32'h00100, 0, 1, "load_pc_unk");
    issue(1, 0, 0, 1, "pcr_unk");
    issue(9, 0, 0, 1, "bus_reset5");

    issue(7, 32'hFFFC0, 0, 1, "cfg_size5");
    issue(7, 32'h00100, 0, 1, "cfg_base5");
    issue(6, 32'h00111, 0, 1, "load_dp_pre");
    issue(4, 0, 9, 1, "dpw_pre9");
    issue(6, 32'h00110, 0, 1, "load_dp_pre2");
    issue(4, 0, 1, 1, "dpw_pre1");
    drain();
    @(posedge clk); #1;
    bus.command = 4'(CMD_DP_WRITE); bus.nibble_in = 4'h7;
    #1 reset = 1'b1;
    #1;
    check("abort.nibble_out", int'(bus.nibble_out), 0);
    check("abort.active", int'(bus.active), 0);
    check("abort.daisy_out", int'(bus.daisy_out), 0);
    check("abort.error", int'(bus.error), 0);
    @(negedge clk); #2;
    bus.command = 4'(CMD_NOP);
    reset = 1'b0;
    model_reset();
    issue(7, 32'hFFFC0, 0, 1, "cfg_size6");
    issue(7, 32'h00100, 0, 1, "cfg_base6");
    issue(5, 32'h00110, 0, 1, "load_pc_abort");
    issue(1, 0, 0, 1, "pcr_kept1");
    issue(1, 0, 0, 1, "pcr_not_aborted");

    for (int i = 0; i < 500; i++) begin
      r = int'($urandom_range(0, 99));
      a = (m_base + $urandom_range(0, 80) + AMOD - 8) % AMOD;
      if      (r < 20) cmd = 1;
      else if (r < 30) cmd = 2;
      else if (r < 45) cmd = 3;
      else if (r < 60) cmd = 4;
      else if (r < 68) cmd = 5;
      else if (r < 76) cmd = 6;
      else if (r < 86) cmd = 7;
      else if (r < 90) cmd = 8;
      else if (r < 95) cmd = 0;
      else if (r < 98) cmd = 9;
      else             cmd = int'($urandom_range(10, 15));
      if (cmd == 7) begin
        if (m_state == 0) a = (AMOD - (32'd1 << $urandom_range(0, 7))) % AMOD;
        else              a = $urandom_range(0, AMOD - 1);
      end
      issue(cmd, a, int'($urandom_range(0, 15)), $urandom_range(0, 9) != 0, "rand");
    end
    drain();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
